// File: rtl/usb_dev_pkg.sv
// Shared PID encodings and responder state names for the device-side link engine.
package usb_dev_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_DATA0 = 4'b0011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010
  } pid_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OUT_WAIT_DATA,
    S_SEND,
    S_IN_WAIT_HS
  } resp_state_t;

endpackage

// File: rtl/usb_dev_timer.sv
// Clear/enable transaction timer; expired while the count sits at TIMEOUT_CYC.
module usb_dev_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_L,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] count;

  assign expired = (count == TW'(TIMEOUT_CYC));

  // Saturates at the limit so a stalled wait state never wraps back to zero.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L)                count <= '0;
    else if (clr)              count <= '0;
    else if (en && !expired)   count <= count + 1'b1;
  end

endmodule

// File: rtl/usb_dev_responder.sv
// Device-side responder: answers OUT with ACK/NAK and a print strobe, answers IN from the scan buffer.
module usb_dev_responder
  import usb_dev_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h0,
  parameter logic [3:0] ENDP_OUT    = 4'd4,
  parameter logic [3:0] ENDP_IN     = 4'd8,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        rx_valid,
  input  logic [3:0]  rx_pid,
  input  logic [6:0]  rx_addr,
  input  logic [3:0]  rx_endp,
  input  logic [63:0] rx_data,
  input  logic        rx_ok,
  output logic        tx_start,
  output logic [3:0]  tx_pid,
  output logic [63:0] tx_data,
  input  logic        tx_busy,
  output logic        print_valid,
  output logic [63:0] print_data,
  input  logic        scan_load,
  input  logic [63:0] scan_data,
  output logic        scan_ready,
  output logic        scan_full
);

  resp_state_t state_q, state_d, ret_q, ret_d;
  logic        send_data_q, send_data_d, seen_busy_q, seen_busy_d;
  logic        tx_start_d, print_valid_d, scan_full_d;
  logic [3:0]  tx_pid_d;
  logic [63:0] tx_data_d, print_data_d, buf_q, buf_d;
  logic        tok_out, tok_in, tmr_clr, tmr_en, expired;

  assign tok_out = rx_valid && rx_ok && (rx_pid == PID_OUT) &&
                   (rx_addr == DEV_ADDR) && (rx_endp == ENDP_OUT);
  assign tok_in  = rx_valid && rx_ok && (rx_pid == PID_IN) &&
                   (rx_addr == DEV_ADDR) && (rx_endp == ENDP_IN);

  // The buffer is locked only while its word is in flight to the host.
  assign scan_ready = !((state_q == S_IN_WAIT_HS) || (state_q == S_SEND && send_data_q));

  assign tmr_en  = (state_q == S_OUT_WAIT_DATA) || (state_q == S_IN_WAIT_HS);
  assign tmr_clr = (state_d != state_q) &&
                   ((state_d == S_OUT_WAIT_DATA) || (state_d == S_IN_WAIT_HS));

  usb_dev_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_L   (rst_L),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      send_data_q <= 1'b0;
      seen_busy_q <= 1'b0;
      tx_start    <= 1'b0;
      tx_pid      <= 4'b0000;
      tx_data     <= '0;
      print_valid <= 1'b0;
      print_data  <= '0;
      buf_q       <= '0;
      scan_full   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      send_data_q <= send_data_d;
      seen_busy_q <= seen_busy_d;
      tx_start    <= tx_start_d;
      tx_pid      <= tx_pid_d;
      tx_data     <= tx_data_d;
      print_valid <= print_valid_d;
      print_data  <= print_data_d;
      buf_q       <= buf_d;
      scan_full   <= scan_full_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    send_data_d   = send_data_q;
    seen_busy_d   = seen_busy_q;
    tx_start_d    = tx_start;
    tx_pid_d      = tx_pid;
    tx_data_d     = tx_data;
    print_valid_d = 1'b0;
    print_data_d  = print_data;
    buf_d         = buf_q;
    scan_full_d   = scan_full;

    // Load first so a same-cycle IN token sees the fresh word via buf_d/scan_full_d.
    if (scan_load && scan_ready) begin
      buf_d       = scan_data;
      scan_full_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (tok_out) begin
          state_d = S_OUT_WAIT_DATA;
        end else if (tok_in) begin
          state_d     = S_SEND;
          tx_start_d  = 1'b1;
          seen_busy_d = 1'b0;
          if (scan_full_d) begin
            tx_pid_d    = PID_DATA0;
            tx_data_d   = buf_d;
            ret_d       = S_IN_WAIT_HS;
            send_data_d = 1'b1;
          end else begin
            tx_pid_d    = PID_NAK;
            ret_d       = S_IDLE;
            send_data_d = 1'b0;
          end
        end
      end
      S_OUT_WAIT_DATA: begin
        if (rx_valid) begin
          state_d     = S_SEND;
          tx_start_d  = 1'b1;
          seen_busy_d = 1'b0;
          ret_d       = S_IDLE;
          send_data_d = 1'b0;
          if (rx_pid == PID_DATA0 && rx_ok) begin
            tx_pid_d      = PID_ACK;
            print_valid_d = 1'b1;
            print_data_d  = rx_data;
          end else begin
            tx_pid_d = PID_NAK;
          end
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (tx_start && !tx_busy) tx_start_d  = 1'b0;
        // Busy only counts once our own packet has been launched.
        if (!tx_start && tx_busy) seen_busy_d = 1'b1;
        if (!tx_start && seen_busy_q && !tx_busy) begin
          state_d     = ret_q;
          send_data_d = 1'b0;
        end
      end
      S_IN_WAIT_HS: begin
        if (rx_valid) begin
          if (rx_pid == PID_ACK && rx_ok) scan_full_d = 1'b0;
          state_d = S_IDLE;
        end else if (expired) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
